clk_divider_multi: RTL and testbench
====================================

CLK_DIVIDER_MULTI -- requirements
Module: clk_divider_multi

Interface
REQ-001 Parameter CH, default 2: number of independent divider channels (1..8).
REQ-002 Parameter CW, default 28: half-period counter and divisor width.
REQ-003 Parameter HALF_INIT, default 25000000: half-period in I_CLK cycles loaded into every channel at reset.
REQ-004 Parameter SW, default 1: width of Wr_Ch (SW >= clog2(CH), minimum 1).
REQ-005 I_CLK  input  1  sole clock; all logic on rising edge.
REQ-006 Rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-007 En  input  CH  per-channel run enable, bit i controls channel i.
REQ-008 Sync  input  1  single-cycle pulse; phase-restarts all channels.
REQ-009 Wr_En  input  1  divisor write strobe.
REQ-010 Wr_Ch  input  SW  target channel index for write.
REQ-011 Wr_Half  input  CW  new half-period value.
REQ-012 O_CLK  output  CH  divided clocks, registered, 50% duty.
REQ-013 O_TICK  output  CH  one-cycle pulse per O_CLK rising edge, registered.

Function
REQ-014 Each channel SHALL hold cnt[CW-1:0], half_act, half_pend and pend_vld.
REQ-015 Enabled channel, no Sync: if cnt == half_act-1 then O_CLK[i] toggles, cnt <= 0; else cnt <= cnt+1.
REQ-016 Output period SHALL be exactly 2*half_act I_CLK cycles; half_act=1 gives I_CLK/2.
REQ-017 Write (Wr_En=1, Wr_Ch<CH) SHALL store max(Wr_Half,1) into half_pend and set pend_vld; Wr_Half=0 is coerced to 1.
REQ-018 Write with Wr_Ch >= CH SHALL be ignored, no state change.
REQ-019 Pending value SHALL transfer to half_act (pend_vld cleared) only on a toggle cycle, Sync cycle, or any cycle the channel is disabled; no output glitch or truncated half-period.
REQ-020 Write in the same cycle as a transfer: the old pending value transfers; the new value becomes pending (pend_vld stays 1).
REQ-021 En[i]=0 SHALL force cnt <= 0, O_CLK[i] <= 0, O_TICK[i] <= 0 next cycle; counting resumes from cnt=0 on re-enable, first toggle (rising) after half_act cycles.
REQ-022 Sync=1 SHALL force cnt <= 0, O_CLK <= 0 on all channels and apply pending divisors, aligning enabled channels' phases.
REQ-023 Priority: Rst > Sync > En low > count.
REQ-024 O_TICK[i] SHALL be 1 exactly in the cycles in which O_CLK[i] is 1 and was 0 the previous cycle.
REQ-025 cnt SHALL never exceed half_act-1; a half_act decrease applied at transfer takes effect from cnt=0.

Reset
REQ-026 Rst=0 at a rising edge: cnt=0, O_CLK=0, O_TICK=0, half_act=half_pend=HALF_INIT, pend_vld=0 for all channels.
REQ-027 Reset mid-operation SHALL abandon pending writes; writes during reset are ignored.

Configuration
REQ-028 Macro CLKDIV_TICK_EN defined: O_TICK generated per REQ-024.
REQ-029 Macro CLKDIV_TICK_EN undefined: O_TICK tied to 0, tick registers not synthesised; O_CLK behaviour unchanged.

Verification
REQ-030 HALF_INIT=3, En=2'b11 after reset -> both O_CLK period 6 cycles, first rise 3 cycles after En, O_TICK one cycle per rise.
REQ-031 Write Wr_Ch=0, Wr_Half=5 mid-half-period -> current half completes at 3, then half-periods of 5; channel 1 unaffected.
REQ-032 Write Wr_Half=0 -> channel runs at half_act=1, O_CLK toggles every cycle.
REQ-033 Write Wr_Ch=2 with CH=2 -> no change on any channel.
REQ-034 Channels at halves 3 and 4, Sync pulse -> both O_CLK low next cycle, both rise together 3 and 4 cycles later respectively from common cnt=0.
REQ-035 Rst=0 asserted mid-count with pending write -> all outputs 0 next edge, half_act back to HALF_INIT, pending discarded.

Source files
------------

// File: rtl/clk_divider_multi.sv
// clk_divider_multi: CH independent 50%-duty clock dividers with glitch-free divisor updates.
// O_TICK rise pulses are generated only when CLKDIV_TICK_EN is defined; otherwise O_TICK is tied low.
module clk_divider_multi #(
    parameter int CH        = 2,
    parameter int CW        = 28,
    parameter int HALF_INIT = 25000000,
    parameter int SW        = 1
) (
    input  logic          I_CLK,
    input  logic          Rst,
    input  logic [CH-1:0] En,
    input  logic          Sync,
    input  logic          Wr_En,
    input  logic [SW-1:0] Wr_Ch,
    input  logic [CW-1:0] Wr_Half,
    output logic [CH-1:0] O_CLK,
    output logic [CH-1:0] O_TICK
);
    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [CW-1:0] cnt_q, cnt_d, act_q, act_d, pend_q, pend_d;
        logic          clk_q, clk_d, pv_q, pv_d, tgl, xfer, wr;
        // Pending divisors only move to the active slot at half-period boundaries, so no half is truncated
        always_comb begin
            wr     = Wr_En && Wr_Ch == SW'(g);
            tgl    = En[g] && !Sync && cnt_q == act_q - 1'b1;
            xfer   = Sync || !En[g] || tgl;
            cnt_d  = xfer ? '0 : cnt_q + 1'b1;
            clk_d  = (Sync || !En[g]) ? 1'b0 : clk_q ^ tgl;
            act_d  = (xfer && pv_q) ? pend_q : act_q;
            pend_d = wr ? ((Wr_Half == '0) ? CW'(1) : Wr_Half) : pend_q;
            pv_d   = wr || (pv_q && !xfer);
        end
        always_ff @(posedge I_CLK) begin
            if (!Rst) begin
                cnt_q  <= '0;
                clk_q  <= 1'b0;
                act_q  <= CW'(HALF_INIT);
                pend_q <= CW'(HALF_INIT);
                pv_q   <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                clk_q  <= clk_d;
                act_q  <= act_d;
                pend_q <= pend_d;
                pv_q   <= pv_d;
            end
        end
        assign O_CLK[g] = clk_q;
`ifdef CLKDIV_TICK_EN
        logic tick_q;
        always_ff @(posedge I_CLK) begin
            tick_q <= Rst && clk_d && !clk_q;
        end
        assign O_TICK[g] = tick_q;
`else
        assign O_TICK[g] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_clk_divider_multi.sv
// tb_clk_divider_multi: directed stimulus with a countdown reference model feeding an
// expected-value queue; a monitor pops one entry per clock and compares O_CLK/O_TICK.
module tb_clk_divider_multi;
    localparam int CH = 2, CW = 8, HI = 3, SW = 2;
`ifdef CLKDIV_TICK_EN
    localparam bit TE = 1'b1;
`else
    localparam bit TE = 1'b0;
`endif
    logic          I_CLK = 1'b0, Rst = 1'b0, Sync = 1'b0, Wr_En = 1'b0;
    logic [CH-1:0] En = '0;
    logic [SW-1:0] Wr_Ch = '0;
    logic [CW-1:0] Wr_Half = '0;
    logic [CH-1:0] O_CLK, O_TICK;

    clk_divider_multi #(.CH(CH), .CW(CW), .HALF_INIT(HI), .SW(SW)) dut (
        .I_CLK(I_CLK), .Rst(Rst), .En(En), .Sync(Sync), .Wr_En(Wr_En),
        .Wr_Ch(Wr_Ch), .Wr_Half(Wr_Half), .O_CLK(O_CLK), .O_TICK(O_TICK)
    );

    always #5 I_CLK = ~I_CLK;

    // model: rem counts edges left until the next toggle
    logic m_clk [CH];
    bit   m_pv  [CH];
    int   m_act [CH], m_pend [CH], m_rem [CH];
    logic [2*CH-1:0] exq [$];
    logic [2*CH-1:0] exp_v;
    int vecs = 0, errs = 0;

    task automatic cyc(input logic r, input logic [CH-1:0] e, input logic s,
                       input logic w, input int ch, input int h);
        logic [CH-1:0] nc, nt;
        @(negedge I_CLK);
        Rst = r; En = e; Sync = s; Wr_En = w; Wr_Ch = SW'(ch); Wr_Half = CW'(h);
        for (int i = 0; i < CH; i++) begin
            int nact;
            nact = m_pv[i] ? m_pend[i] : m_act[i];
            if (!r) begin
                m_act[i] = HI; m_pend[i] = HI; m_pv[i] = 0; m_rem[i] = HI; nc[i] = 1'b0;
            end else begin
                if (s || !e[i]) begin
                    nc[i] = 1'b0; m_act[i] = nact; m_pv[i] = 0; m_rem[i] = nact;
                end else if (m_rem[i] == 1) begin
                    nc[i] = !m_clk[i]; m_act[i] = nact; m_pv[i] = 0; m_rem[i] = nact;
                end else begin
                    nc[i] = m_clk[i]; m_rem[i] = m_rem[i] - 1;
                end
                if (w && ch == i) begin
                    m_pend[i] = (h == 0) ? 1 : h; m_pv[i] = 1;
                end
            end
            nt[i] = TE && nc[i] && !m_clk[i];
            m_clk[i] = nc[i];
        end
        exq.push_back({nc, nt});
    endtask

    task automatic run(input int n, input logic [CH-1:0] e);
        repeat (n) cyc(1'b1, e, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        forever begin
            @(posedge I_CLK);
            #1;
            if (exq.size() > 0) begin
                exp_v = exq.pop_front();
                vecs++;
                if ({O_CLK, O_TICK} !== exp_v) begin
                    errs++;
                    $display("FAIL vec%0d clk_tick got %b want %b", vecs, {O_CLK, O_TICK}, exp_v);
                end
            end
        end
    end

    initial begin
        repeat (3) cyc(1'b0, '0, 1'b0, 1'b0, 0, 0);
        cyc(1'b0, 2'b11, 1'b0, 1'b1, 0, 9);
        run(14, 2'b11);
        cyc(1'b1, 2'b11, 1'b0, 1'b1, 0, 5);
        run(22, 2'b11);
        cyc(1'b1, 2'b11, 1'b0, 1'b1, 1, 0);
        run(8, 2'b11);
        cyc(1'b1, 2'b11, 1'b0, 1'b1, 2, 7);
        cyc(1'b1, 2'b11, 1'b0, 1'b1, 3, 7);
        run(6, 2'b11);
        cyc(1'b1, 2'b11, 1'b0, 1'b1, 0, 3);
        cyc(1'b1, 2'b11, 1'b0, 1'b1, 1, 4);
        run(12, 2'b11);
        cyc(1'b1, 2'b11, 1'b1, 1'b0, 0, 0);
        run(12, 2'b11);
        run(4, 2'b01);
        run(10, 2'b11);
        for (int i = 0; i < 6; i++) cyc(1'b1, 2'b11, 1'b0, 1'b1, 0, 2 + (i % 2));
        run(12, 2'b11);
        cyc(1'b1, 2'b11, 1'b0, 1'b1, 1, 2);
        cyc(1'b1, 2'b11, 1'b1, 1'b0, 0, 0);
        run(8, 2'b11);
        cyc(1'b1, 2'b11, 1'b0, 1'b1, 0, 9);
        cyc(1'b0, 2'b11, 1'b0, 1'b0, 0, 0);
        run(10, 2'b11);
        repeat (4) @(posedge I_CLK);
        #2;
        if (exq.size() != 0) begin
            errs++;
            $display("FAIL drain left %0d want 0", exq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
